// File: rtl/tlb_pkg.sv
// Shared types and default sizing for the fully-associative TLB.
package tlb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    WALK = 2'd2
  } tlb_state_e;

  localparam int DEF_N_ENTRIES    = 4;
  localparam int DEF_PAGE_WIDTH   = 20;
  localparam int DEF_MISS_LATENCY = 5;

endpackage

// File: rtl/tlb_cam.sv
// Translation storage: valid/vpage/ppage per entry, parallel match,
// first-invalid search, one read port and one write port.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int N_ENTRIES  = DEF_N_ENTRIES,
  parameter int PAGE_WIDTH = DEF_PAGE_WIDTH,
  parameter int IDX_W      = $clog2(N_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [PAGE_WIDTH-1:0] lk_vpage_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic                  any_inv_o,
  output logic [IDX_W-1:0]      inv_idx_o,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [PAGE_WIDTH-1:0] rd_ppage_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [PAGE_WIDTH-1:0] wr_vpage_i,
  input  logic [PAGE_WIDTH-1:0] wr_ppage_i
);

  logic [N_ENTRIES-1:0]                 valid_q;
  logic [N_ENTRIES-1:0][PAGE_WIDTH-1:0] vpage_q;
  logic [N_ENTRIES-1:0][PAGE_WIDTH-1:0] ppage_q;

  // Entry storage; clear drops only the valid bits, data is don't-care once invalid.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      vpage_q[wr_idx_i] <= wr_vpage_i;
      ppage_q[wr_idx_i] <= wr_ppage_i;
    end
  end

  // Parallel match and first-invalid search; scanning downward leaves the lowest index.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    any_inv_o = 1'b0;
    inv_idx_o = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (vpage_q[i] == lk_vpage_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        any_inv_o = 1'b1;
        inv_idx_o = IDX_W'(i);
      end
    end
  end

  assign rd_ppage_o = ppage_q[rd_idx_i];

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB: one-cycle hits, fixed-latency walk on miss
// (translation = vpage + 1), vpage 0 faults, round-robin replacement.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int N_ENTRIES    = DEF_N_ENTRIES,
  parameter int PAGE_WIDTH   = DEF_PAGE_WIDTH,
  parameter int MISS_LATENCY = DEF_MISS_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [PAGE_WIDTH-1:0] req_vpage,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [PAGE_WIDTH-1:0] resp_ppage,
  output logic                  resp_hit,
  output logic                  resp_exception
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(MISS_LATENCY + 1);

  tlb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PAGE_WIDTH-1:0] vpage_q;
  logic [IDX_W-1:0]      rr_q;
  logic                  kill_q;
  logic                  resp_valid_q, resp_hit_q, resp_exc_q;
  logic [PAGE_WIDTH-1:0] resp_ppage_q;

  logic                  cam_hit, cam_any_inv;
  logic [IDX_W-1:0]      cam_hit_idx, cam_inv_idx, victim_idx;
  logic [PAGE_WIDTH-1:0] cam_hit_ppage, walk_ppage;
  logic                  accept, walk_done, fill_en;

  assign req_ready  = (state_q == IDLE) && !flush && !rst;
  assign accept     = req_valid && req_ready;
  assign walk_done  = (state_q == WALK) && (cnt_q == CNT_W'(1));
  // A flush seen at any point of the walk (including its last edge) cancels the fill.
  assign fill_en    = walk_done && !kill_q && !flush;
  assign victim_idx = cam_any_inv ? cam_inv_idx : rr_q;
  assign walk_ppage = vpage_q + PAGE_WIDTH'(1);

  tlb_cam #(
    .N_ENTRIES (N_ENTRIES),
    .PAGE_WIDTH(PAGE_WIDTH),
    .IDX_W     (IDX_W)
  ) u_cam (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .lk_vpage_i(req_vpage),
    .hit_o     (cam_hit),
    .hit_idx_o (cam_hit_idx),
    .any_inv_o (cam_any_inv),
    .inv_idx_o (cam_inv_idx),
    .rd_idx_i  (cam_hit_idx),
    .rd_ppage_o(cam_hit_ppage),
    .wr_en_i   (fill_en),
    .wr_idx_i  (victim_idx),
    .wr_vpage_i(vpage_q),
    .wr_ppage_i(walk_ppage)
  );

  // Control FSM with registered response; response fields default to 0 every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vpage_q      <= '0;
      rr_q         <= '0;
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_exc_q   <= 1'b0;
      resp_ppage_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_exc_q   <= 1'b0;
      resp_ppage_q <= '0;
      case (state_q)
        IDLE: if (accept) begin
          if (req_vpage == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_exc_q   <= 1'b1;
          end else if (cam_hit) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_ppage_q <= cam_hit_ppage;
          end else begin
            state_q <= WALK;
            cnt_q   <= CNT_W'(MISS_LATENCY);
            vpage_q <= req_vpage;
            kill_q  <= 1'b0;
          end
        end
        WALK: begin
          if (flush) kill_q <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_ppage_q <= walk_ppage;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Pointer only moves when it actually picked the victim.
      if (flush)
        rr_q <= '0;
      else if (fill_en && !cam_any_inv)
        rr_q <= (rr_q == IDX_W'(N_ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_ppage     = resp_ppage_q;
  assign resp_hit       = resp_hit_q;
  assign resp_exception = resp_exc_q;

endmodule
